// File: rtl/eth_pll_pkg.sv
// Shared types and defaults for the Ethernet PLL reset sequencer.
// State encoding, default timing constants and a saturating helper.
package eth_pll_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_t;

  localparam int unsigned DEF_PWRDN_CYCLES  = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
  localparam int unsigned DEF_SETTLE_CYCLES = 256;
  localparam int unsigned DEF_LOSS_FILTER   = 4;

  localparam int unsigned LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(
    input logic [LOSS_CNT_W-1:0] v
  );
    return (v == LOSS_CNT_MAX) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_pll_lock_filt.sv
// LOCK synchroniser and lock-loss glitch filter.
// o_loss flags LOSS_FILTER consecutive low lk cycles while i_run is set.
module eth_pll_lock_filt
  import eth_pll_pkg::*;
#(
  parameter int unsigned LOSS_FILTER = DEF_LOSS_FILTER
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_lock,
  input  logic i_run,
  output logic o_lk,
  output logic o_loss
);

  localparam int unsigned FW = $clog2(LOSS_FILTER) + 1;
  localparam logic [FW-1:0] F_LAST = FW'(LOSS_FILTER - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [FW-1:0] r_fcnt;
  logic          w_at_last;

  // two-flop synchroniser for the raw PLL lock
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_lock;
      r_sync2 <= r_sync1;
    end
  end

  // count consecutive low lk cycles in RUN; any high sample clears it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fcnt <= '0;
    end else if (!i_run || r_sync2) begin
      r_fcnt <= '0;
    end else if (!w_at_last) begin
      r_fcnt <= r_fcnt + FW'(1);
    end
  end

  assign w_at_last = (r_fcnt == F_LAST);
  assign o_lk      = r_sync2;
  assign o_loss    = i_run & ~r_sync2 & w_at_last;

endmodule

// File: rtl/eth_pll_rst_seq.sv
// Ethernet PLL power/lock sequencer generating the eth-domain reset.
// Define ETH_PLL_AUTO_RETRY_EN for a one-cycle FAIL followed by power-cycle.
module eth_pll_rst_seq
  import eth_pll_pkg::*;
#(
  parameter int unsigned PWRDN_CYCLES  = DEF_PWRDN_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned LOSS_FILTER   = DEF_LOSS_FILTER
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable_i,
  input  logic                  pll_lock_i,
  output logic                  pll_pwrdn_n_o,
  output logic                  eth_rst_o,
  output logic                  locked_o,
  output logic                  fail_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned PW_W  = $clog2(PWRDN_CYCLES) + 1;
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES) + 1;

  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PWRDN_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  pll_state_t            r_state;
  logic [PW_W-1:0]       r_pw_cnt;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic [SET_W-1:0]      r_set_cnt;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic                  r_pwrdn_n;
  logic                  r_eth_rst;
  logic                  r_locked;
  logic                  r_fail;

  pll_state_t            w_next;
  logic [PW_W-1:0]       w_pw_nx;
  logic [TMO_W-1:0]      w_tmo_nx;
  logic [SET_W-1:0]      w_set_nx;
  logic                  w_loss_inc;
  logic                  w_lk;
  logic                  w_loss;
  logic                  w_run;
  logic                  w_pwrdn_n_nx;
  logic                  w_eth_rst_nx;
  logic                  w_locked_nx;
  logic                  w_fail_nx;

  assign w_run = (r_state == ST_RUN);

  eth_pll_lock_filt #(
    .LOSS_FILTER (LOSS_FILTER)
  ) u_lock_filt (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_lock (pll_lock_i),
    .i_run  (w_run),
    .o_lk   (w_lk),
    .o_loss (w_loss)
  );

  // state, counters and registered outputs; reset forces safe outputs at once
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_PWRDN;
      r_pw_cnt   <= '0;
      r_tmo_cnt  <= '0;
      r_set_cnt  <= '0;
      r_loss_cnt <= '0;
      r_pwrdn_n  <= 1'b0;
      r_eth_rst  <= 1'b1;
      r_locked   <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_pw_cnt   <= w_pw_nx;
      r_tmo_cnt  <= w_tmo_nx;
      r_set_cnt  <= w_set_nx;
      r_pwrdn_n  <= w_pwrdn_n_nx;
      r_eth_rst  <= w_eth_rst_nx;
      r_locked   <= w_locked_nx;
      r_fail     <= w_fail_nx;
      if (w_loss_inc) begin
        r_loss_cnt <= sat_inc(r_loss_cnt);
      end
    end
  end

  // next-state, counter updates and output decode of the next state
  always_comb begin
    w_next     = r_state;
    w_pw_nx    = '0;
    w_tmo_nx   = r_tmo_cnt;
    w_set_nx   = '0;
    w_loss_inc = 1'b0;

    unique case (r_state)
      ST_PWRDN: begin
        w_tmo_nx = '0;
        if (enable_i) begin
          if (r_pw_cnt == PW_LAST) begin
            w_next = ST_WAIT_LOCK;
          end else begin
            w_pw_nx = r_pw_cnt + PW_W'(1);
          end
        end
      end

      ST_WAIT_LOCK: begin
        if (!enable_i) begin
          w_next   = ST_PWRDN;
          w_tmo_nx = '0;
        end else if (w_lk) begin
          w_next = ST_SETTLE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_next     = ST_FAIL;
          w_tmo_nx   = '0;
          w_loss_inc = 1'b1;
        end else begin
          w_tmo_nx = r_tmo_cnt + TMO_W'(1);
        end
      end

      ST_SETTLE: begin
        if (!enable_i) begin
          w_next   = ST_PWRDN;
          w_tmo_nx = '0;
        end else if (!w_lk) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_set_cnt == SET_LAST) begin
          w_next = ST_RUN;
        end else begin
          w_set_nx = r_set_cnt + SET_W'(1);
        end
      end

      ST_RUN: begin
        w_tmo_nx = '0;
        if (!enable_i) begin
          w_next = ST_PWRDN;
        end else if (w_loss) begin
          w_next     = ST_PWRDN;
          w_loss_inc = 1'b1;
        end
      end

      ST_FAIL: begin
        w_tmo_nx = '0;
`ifdef ETH_PLL_AUTO_RETRY_EN
        w_next = ST_PWRDN;
`else
        if (!enable_i) begin
          w_next = ST_PWRDN;
        end
`endif
      end

      default: begin
        w_next   = ST_PWRDN;
        w_tmo_nx = '0;
      end
    endcase

    w_pwrdn_n_nx = (w_next == ST_WAIT_LOCK) ||
                   (w_next == ST_SETTLE) ||
                   (w_next == ST_RUN);
    w_eth_rst_nx = (w_next != ST_RUN);
    w_locked_nx  = (w_next == ST_RUN);
    w_fail_nx    = (w_next == ST_FAIL);
  end

  assign pll_pwrdn_n_o = r_pwrdn_n;
  assign eth_rst_o     = r_eth_rst;
  assign locked_o      = r_locked;
  assign fail_o        = r_fail;
  assign loss_cnt_o    = r_loss_cnt;

endmodule

// File: doc/eth_pll_rst_seq.md
ETH_PLL_RST_SEQ -- requirements
Module: eth_pll_rst_seq

Interface
REQ-001 SHALL have parameter PWRDN_CYCLES, default 16, PLL power-down hold time in wb_clk_i cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, maximum cycles to wait for PLL lock.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256, cycles LOCK must stay high before eth reset release.
REQ-004 SHALL have parameter LOSS_FILTER, default 4, consecutive low-LOCK cycles that count as lock loss.
REQ-005 SHALL have ports: wb_clk_i  in  1  free-running reference clock, also feeding the PLL input; the block's single clock.
REQ-006 SHALL have ports: wb_rst_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: enable_i  in  1  sequencer run request, level.
REQ-008 SHALL have ports: pll_lock_i  in  1  raw PLL LOCK, asynchronous to wb_clk_i.
REQ-009 SHALL have ports: pll_pwrdn_n_o  out  1  to PLL POWERDOWN; 0 = PLL powered down.
REQ-010 SHALL have ports: eth_rst_o  out  1  active-high reset for the Ethernet clock domain.
REQ-011 SHALL have ports: locked_o  out  1  high only in RUN.
REQ-012 SHALL have ports: fail_o  out  1  high in FAIL.
REQ-013 SHALL have ports: loss_cnt_o  out  8  saturating count of timeouts plus lock losses.

Function
REQ-014 SHALL synchronise pll_lock_i through two wb_clk_i flops; all decisions use the synchronised value lk.
REQ-015 SHALL implement states PWRDN, WAIT_LOCK, SETTLE, RUN, FAIL.
REQ-016 PWRDN: pll_pwrdn_n_o=0, eth_rst_o=1; after PWRDN_CYCLES cycles with enable_i=1 -> WAIT_LOCK; counter holds at 0 while enable_i=0.
REQ-017 WAIT_LOCK: pll_pwrdn_n_o=1; lk=1 -> SETTLE; LOCK_TIMEOUT cycles elapsed with no lk -> FAIL, loss_cnt_o+1.
REQ-018 SETTLE: lk=0 any cycle -> restart settle count in WAIT_LOCK (timeout counter not reset); SETTLE_CYCLES consecutive lk=1 -> RUN.
REQ-019 RUN: eth_rst_o deasserts on the first RUN cycle (registered output); locked_o=1.
REQ-020 RUN: LOSS_FILTER consecutive lk=0 -> PWRDN, loss_cnt_o+1, eth_rst_o=1 next cycle; shorter low glitches ignored, filter counter clears on lk=1.
REQ-021 enable_i=0 in any state except PWRDN -> PWRDN next cycle, no loss_cnt_o increment.
REQ-022 loss_cnt_o SHALL saturate at 255 and never wrap.
REQ-023 eth_rst_o SHALL be 1 in every state except RUN; never deasserted for a glitch.
REQ-024 All counters sized by $clog2 of their parameter plus 1; simultaneous timeout and lk rise: lk wins (-> SETTLE).

Reset
REQ-025 On wb_rst_i=1: state PWRDN, pll_pwrdn_n_o=0, eth_rst_o=1, locked_o=0, fail_o=0, loss_cnt_o=0, sync flops 0, all counters 0.
REQ-026 Reset asserted mid-RUN SHALL assert eth_rst_o and power down the PLL asynchronously.

Configuration
REQ-027 Macro ETH_PLL_AUTO_RETRY_EN defined: FAIL asserts fail_o for one cycle then -> PWRDN (power-cycle retry).
REQ-028 Macro absent: FAIL is sticky, pll_pwrdn_n_o=0, fail_o=1 until enable_i=0 (-> PWRDN) or wb_rst_i.

Structure
REQ-029 State encoding enum and default parameter constants SHALL live in shared package eth_pll_pkg.
REQ-030 The lock synchroniser plus loss glitch filter SHALL be sub-module eth_pll_lock_filt; the FSM stays in eth_pll_rst_seq.

Verification
REQ-031 Reset, enable_i=1, lock rises 20 cycles after pll_pwrdn_n_o=1 -> eth_rst_o falls exactly 2+256 cycles after lock rise (+1 register); locked_o=1.
REQ-032 RUN, lock low 3 cycles -> no change; low 4 cycles -> PWRDN, eth_rst_o=1, loss_cnt_o=1.
REQ-033 Lock never rises -> FAIL after 4096 cycles, loss_cnt_o=1; with ETH_PLL_AUTO_RETRY_EN re-enters PWRDN, without stays in FAIL with fail_o=1.
REQ-034 SETTLE, lock drops at cycle 100 -> back to WAIT_LOCK, full 256-cycle settle required after re-lock.
REQ-035 Force 300 loss events -> loss_cnt_o holds 255.
REQ-036 wb_rst_i pulsed mid-RUN -> eth_rst_o=1 and pll_pwrdn_n_o=0 same cycle, all outputs at reset values.
